// File: rtl/hash_unit.sv
// Handshaked key hasher: sum-fold, XOR-fold or CRC-8 over a KEY_BYTES key,
// consuming LANES bytes per beat and holding the result until it is accepted.
module hash_unit #(
   parameter int KEY_BYTES = 8,
   parameter int LANES     = 2,
   parameter int DATA_W    = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [8*KEY_BYTES-1:0] key_i,
   input  logic [1:0]             mode_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [DATA_W-1:0]      hash_val_o
);

   localparam int BEATS  = (KEY_BYTES + LANES - 1) / LANES;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_FOLD  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                 r_state;
   logic [8*KEY_BYTES-1:0] r_key;
   logic [1:0]             r_mode;
   logic [15:0]            r_acc;
   logic [BEAT_W-1:0]      r_beat;
   logic [DATA_W-1:0]      r_hash;
   logic                   r_in_ready;
   logic                   r_out_valid;
   logic [15:0]            w_acc_next;
   logic [8:0]             w_fold;

   // CRC-8, polynomial 0x07, MSB first, one byte
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         if (c[7]) begin
            c = {c[6:0], 1'b0} ^ 8'h07;
         end else begin
            c = {c[6:0], 1'b0};
         end
      end
      return c;
   endfunction

   function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] key, input int idx);
      logic [8*KEY_BYTES-1:0] sh;
      sh = key >> (8 * idx);
      return sh[7:0];
   endfunction

   // One beat of accumulation; lanes past the last key byte are skipped, not padded
   always_comb begin
      w_acc_next = r_acc;
      for (int l = 0; l < LANES; l++) begin
         if (int'(r_beat) * LANES + l < KEY_BYTES) begin
            case (r_mode)
               2'd1:    w_acc_next = {8'h00, w_acc_next[7:0] ^
                                      key_byte(r_key, KEY_BYTES - 1 - (int'(r_beat) * LANES + l))};
               2'd2:    w_acc_next = {8'h00, crc8_byte(w_acc_next[7:0],
                                      key_byte(r_key, KEY_BYTES - 1 - (int'(r_beat) * LANES + l)))};
               default: w_acc_next = w_acc_next + {8'h00,
                                      key_byte(r_key, KEY_BYTES - 1 - (int'(r_beat) * LANES + l))};
            endcase
         end else begin
            w_acc_next = w_acc_next;
         end
      end
   end

   // Final fold of the accumulator into the 9-bit result
   always_comb begin
      w_fold = 9'd0;
      case (r_mode)
         2'd1, 2'd2: w_fold = {1'b0, r_acc[7:0]};
         default:    w_fold = {1'b0, r_acc[15:8]} + {1'b0, r_acc[7:0]};
      endcase
   end

   // Control FSM with registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_key       <= '0;
         r_mode      <= 2'd0;
         r_acc       <= 16'd0;
         r_beat      <= '0;
         r_hash      <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid_i && r_in_ready) begin
                  r_key      <= key_i;
                  r_mode     <= (mode_i == 2'd3) ? 2'd0 : mode_i;
                  r_acc      <= 16'd0;
                  r_beat     <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_ACCUM;
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
            S_ACCUM: begin
               r_acc <= w_acc_next;
               if (r_beat == LAST_BEAT) begin
                  r_state <= S_FOLD;
               end else begin
                  r_beat <= r_beat + BEAT_W'(1);
               end
            end
            S_FOLD: begin
               r_hash      <= DATA_W'(w_fold);
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready_i) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready_o  = r_in_ready;
   assign out_valid_o = r_out_valid;
   assign hash_val_o  = r_hash;

endmodule

// File: tb/tb_hash_unit.sv
// Self-checking bench for hash_unit: default instance (8 bytes, 2 lanes) and a
// 5-byte/2-lane instance, checked against a bytewise/bitwise reference model.
module tb_hash_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid0, in_valid1;
   logic        in_ready0, in_ready1;
   logic [63:0] key0;
   logic [39:0] key1;
   logic [1:0]  mode0, mode1;
   logic        out_valid0, out_valid1;
   logic        out_ready0, out_ready1;
   logic [31:0] hash0, hash1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   hash_unit u_dut0 (
      .clk(clk), .rst(rst), .in_valid_i(in_valid0), .in_ready_o(in_ready0),
      .key_i(key0), .mode_i(mode0), .out_valid_o(out_valid0),
      .out_ready_i(out_ready0), .hash_val_o(hash0)
   );

   hash_unit #(.KEY_BYTES(5), .LANES(2), .DATA_W(32)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
      .key_i(key1), .mode_i(mode1), .out_valid_o(out_valid1),
      .out_ready_i(out_ready1), .hash_val_o(hash1)
   );

   // Reference: sum/XOR over all bytes; CRC as a bit-serial LFSR over the
   // message stream, highest-index byte first, MSB first.
   function automatic logic [31:0] model_hash(input logic [63:0] key, input int nbytes,
                                              input logic [1:0] mode);
      int         s;
      logic [7:0] x, c, b;
      logic       fb;
      s = 0; x = 8'h00; c = 8'h00;
      for (int k = nbytes - 1; k >= 0; k--) begin
         b = key[8*k +: 8];
         s = s + int'(b);
         x = x ^ b;
         for (int j = 7; j >= 0; j--) begin
            fb = c[7] ^ b[j];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
         end
      end
      case (mode)
         2'd1:    return {24'd0, x};
         2'd2:    return {24'd0, c};
         default: return 32'((s >> 8) + (s & 255));
      endcase
   endfunction

   // Drive one key through instance sel, returning result and acceptance-to-valid edges
   task automatic run_one(input int sel, input logic [63:0] key, input logic [1:0] mode,
                          output logic [31:0] h, output int lat);
      int w;
      w = 0;
      while (!(sel == 1 ? in_ready1 : in_ready0) && w < 20) begin
         @(posedge clk); #1; w++;
      end
      if (sel == 1) begin in_valid1 = 1'b1; key1 = key[39:0]; mode1 = mode; end
      else          begin in_valid0 = 1'b1; key0 = key;       mode0 = mode; end
      @(posedge clk); #1;
      // Input changes after acceptance must not matter
      in_valid0 = 1'b0; in_valid1 = 1'b0;
      if (sel == 1) begin key1 = {$urandom, $urandom}; mode1 = 2'($urandom); end
      else          begin key0 = {$urandom, $urandom}; mode0 = 2'($urandom); end
      lat = 0;
      while (!(sel == 1 ? out_valid1 : out_valid0) && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      h = (sel == 1) ? hash1 : hash0;
      if (sel == 1) out_ready1 = 1'b1; else out_ready0 = 1'b1;
      @(posedge clk); #1;
      out_ready0 = 1'b0; out_ready1 = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready0 !== 1'b0 || out_valid0 !== 1'b0 || hash0 !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b hash=%h, want 0 0 0",
                  in_ready0, out_valid0, hash0);
      end
      checks++;
      if (in_ready1 !== 1'b0 || out_valid1 !== 1'b0 || hash1 !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs_k5: got rdy=%b vld=%b hash=%h, want 0 0 0",
                  in_ready1, out_valid1, hash1);
      end
      rst = 1'b0;
      checks++;
      if (in_ready0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_same_cycle: in_ready=%b, want 0", in_ready0);
      end
      @(posedge clk); #1;
      checks++;
      if (in_ready0 !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_next_cycle: in_ready=%b, want 1", in_ready0);
      end
   endtask

   task automatic test_directed;
      logic [63:0] keys [6];
      logic [1:0]  modes[6];
      logic [31:0] exps [6];
      logic [31:0] h;
      int          lat;
      keys[0] = 64'h0807060504030201; modes[0] = 2'd0; exps[0] = 32'h24;
      keys[1] = 64'hFFFFFFFFFFFFFFFF; modes[1] = 2'd0; exps[1] = 32'hFF;
      keys[2] = 64'hFFFFFFFFFFFFFFFF; modes[2] = 2'd3; exps[2] = 32'hFF;
      keys[3] = 64'h0807060504030201; modes[3] = 2'd1; exps[3] = 32'h08;
      keys[4] = 64'h0000000000000001; modes[4] = 2'd2; exps[4] = 32'h07;
      keys[5] = 64'h0000000000000000; modes[5] = 2'd2; exps[5] = 32'h00;
      for (int i = 0; i < 6; i++) begin
         run_one(0, keys[i], modes[i], h, lat);
         checks++;
         if (h !== exps[i]) begin
            errors++;
            $display("FAIL directed_hash[%0d]: got %h, want %h", i, h, exps[i]);
         end
         checks++;
         if (lat !== 5) begin
            errors++;
            $display("FAIL directed_latency[%0d]: got %0d edges, want 5", i, lat);
         end
         checks++;
         if (in_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL directed_ready_after[%0d]: got %b, want 1", i, in_ready0);
         end
      end
   endtask

   task automatic test_random;
      logic [63:0] k;
      logic [1:0]  m;
      logic [31:0] h;
      int          lat;
      for (int i = 0; i < 30; i++) begin
         k = {$urandom, $urandom};
         m = 2'($urandom_range(0, 3));
         run_one(0, k, m, h, lat);
         checks++;
         if (h !== model_hash(k, 8, m)) begin
            errors++;
            $display("FAIL random_hash[%0d]: key=%h mode=%0d got %h, want %h",
                     i, k, m, h, model_hash(k, 8, m));
         end
      end
   endtask

   task automatic test_partial_beat;
      logic [63:0] k;
      logic [1:0]  m;
      logic [31:0] h;
      int          lat;
      run_one(1, 64'h0000005040302010, 2'd0, h, lat);
      checks++;
      if (h !== 32'hF0) begin
         errors++;
         $display("FAIL partial_hash: got %h, want f0", h);
      end
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("FAIL partial_latency: got %0d edges, want 4", lat);
      end
      for (int i = 0; i < 10; i++) begin
         k = {24'd0, 8'($urandom), $urandom};
         m = 2'($urandom_range(0, 3));
         run_one(1, k, m, h, lat);
         checks++;
         if (h !== model_hash(k, 5, m)) begin
            errors++;
            $display("FAIL partial_random[%0d]: key=%h mode=%0d got %h, want %h",
                     i, k[39:0], m, h, model_hash(k, 5, m));
         end
      end
   endtask

   task automatic test_stall;
      logic [63:0] ka, kb;
      logic [31:0] held;
      int          w;
      ka = {$urandom, $urandom};
      kb = {$urandom, $urandom};
      in_valid0 = 1'b1; key0 = ka; mode0 = 2'd2;
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      w = 0;
      while (!out_valid0 && w < 50) begin @(posedge clk); #1; w++; end
      held = hash0;
      checks++;
      if (held !== model_hash(ka, 8, 2'd2)) begin
         errors++;
         $display("FAIL stall_first_hash: got %h, want %h", held, model_hash(ka, 8, 2'd2));
      end
      in_valid0 = 1'b1; key0 = kb; mode0 = 2'd1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid0 !== 1'b1 || hash0 !== held || in_ready0 !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: vld=%b hash=%h rdy=%b, want 1 %h 0",
                     i, out_valid0, hash0, in_ready0, held);
         end
      end
      out_ready0 = 1'b1;
      @(posedge clk); #1;
      out_ready0 = 1'b0;
      checks++;
      if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || hash0 !== held) begin
         errors++;
         $display("FAIL stall_release: rdy=%b vld=%b hash=%h, want 1 0 %h",
                  in_ready0, out_valid0, hash0, held);
      end
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      w = 0;
      while (!out_valid0 && w < 50) begin @(posedge clk); #1; w++; end
      checks++;
      if (hash0 !== model_hash(kb, 8, 2'd1)) begin
         errors++;
         $display("FAIL stall_pending_key: got %h, want %h", hash0, model_hash(kb, 8, 2'd1));
      end
      out_ready0 = 1'b1;
      @(posedge clk); #1;
      out_ready0 = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [63:0] k;
      int          acc_cyc[$];
      int          w;
      k = {$urandom, $urandom};
      in_valid0 = 1'b1; key0 = k; mode0 = 2'd0; out_ready0 = 1'b1;
      for (int c = 0; c < 36; c++) begin
         if (in_ready0) acc_cyc.push_back(c);
         if (out_valid0) begin
            checks++;
            if (hash0 !== model_hash(k, 8, 2'd0)) begin
               errors++;
               $display("FAIL b2b_hash at cycle %0d: got %h, want %h",
                        c, hash0, model_hash(k, 8, 2'd0));
            end
         end
         @(posedge clk); #1;
      end
      in_valid0 = 1'b0;
      checks++;
      if (acc_cyc.size() < 4) begin
         errors++;
         $display("FAIL b2b_count: got %0d acceptances, want at least 4", acc_cyc.size());
      end else begin
         for (int i = 1; i < 4; i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] !== 7) begin
               errors++;
               $display("FAIL b2b_interval[%0d]: got %0d cycles, want 7",
                        i, acc_cyc[i] - acc_cyc[i-1]);
            end
         end
      end
      w = 0;
      while (!in_ready0 && w < 20) begin @(posedge clk); #1; w++; end
      out_ready0 = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic [31:0] h;
      int          lat;
      logic        saw_valid;
      run_one(0, 64'h0807060504030201, 2'd0, h, lat);
      in_valid0 = 1'b1; key0 = 64'h1122334455667788; mode0 = 2'd0;
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid0 !== 1'b0 || hash0 !== 32'd0 || in_ready0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_outputs: vld=%b hash=%h rdy=%b, want 0 0 0",
                  out_valid0, hash0, in_ready0);
      end
      rst = 1'b0;
      saw_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid0 || hash0 !== 32'd0) saw_valid = 1'b1;
      end
      checks++;
      if (saw_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_no_result: got partial result presented, want none");
      end
      checks++;
      if (in_ready0 !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_ready: got %b, want 1", in_ready0);
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid0 = 1'b0; in_valid1 = 1'b0;
      key0 = 64'd0; key1 = 40'd0;
      mode0 = 2'd0; mode1 = 2'd0;
      out_ready0 = 1'b0; out_ready1 = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_partial_beat();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hash_unit.md
# hash_unit

Parametrised, handshaked key-hashing engine for the match-action lookup path. It accepts a KEY_BYTES-wide key and computes an 8-bit hash in one of three selectable modes: byte-sum fold, XOR fold, or CRC-8. It processes LANES key bytes per cycle and holds the result until the consumer accepts it. It sits between the key extractor and the table-address generator, and replaces the fixed 8-byte, sum-only, level-start hasher.

## Interface
- KEY_BYTES, 8: key width in bytes; legal range 1..64.
- LANES, 2: key bytes consumed per cycle; legal range 1..KEY_BYTES.
- DATA_W, 32: width of hash_val_o; must be ≥ 9.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid_i  in  1  key and mode valid.
- in_ready_o  out  1  unit can accept a key.
- key_i  in  8*KEY_BYTES  key; byte k = key_i[8k+7:8k].
- mode_i  in  2  0 = sum fold, 1 = XOR fold, 2 = CRC-8, 3 = treated as 0.
- out_valid_o  out  1  hash_val_o valid.
- out_ready_i  in  1  consumer accepts the result.
- hash_val_o  out  DATA_W  hash result, zero-extended.

## Operation
- State machine: IDLE → ACCUM → FOLD → DONE → IDLE.
- IDLE:
  - in_ready_o = 1.
  - On in_valid_i && in_ready_o: capture key_i and mode_i into internal registers, clear the accumulator and beat counter, go to ACCUM.
  - Input changes after acceptance have no effect.
- ACCUM runs for BEATS = ceil(KEY_BYTES/LANES) cycles. Bytes are consumed highest index first: beat 0 takes bytes KEY_BYTES-1 down to KEY_BYTES-LANES.
  - On the final beat, only the remaining KEY_BYTES mod LANES bytes are consumed when that value is nonzero.
  - No padding bytes enter the computation.
- Per-mode accumulation:
  - Sum: 16-bit accumulator acc += byte. Cannot overflow for KEY_BYTES ≤ 64.
  - XOR: 8-bit accumulator acc ^= byte.
  - CRC-8: polynomial 0x07, init 0x00, no reflection, no final XOR, MSB of each byte first. The LANES byte updates are chained combinationally within one cycle.
- FOLD (1 cycle) writes the result register:
  - Sum: result = acc[15:8] + acc[7:0], 9-bit result.
  - XOR and CRC: result = acc[7:0].
  - hash_val_o = zero-extended result.
- DONE:
  - out_valid_o = 1; hash_val_o is held stable.
  - On out_ready_i = 1, go to IDLE.
  - A consumer that never accepts stalls the unit indefinitely. No key is dropped; in_ready_o stays 0.
- out_ready_i is ignored outside DONE.
- in_valid_i is ignored outside IDLE.
- mode 3 produces results bit-identical to mode 0.

## Timing
- Reset:
  - While rst = 1: state = IDLE, in_ready_o = 0, out_valid_o = 0, hash_val_o = 0, accumulator and beat counter = 0.
  - in_ready_o first reads 1 on the cycle after rst deasserts.
- Latency: with acceptance at clock edge E, out_valid_o rises after edge E+BEATS+1.
  - Default parameters: BEATS = 4, so out_valid_o rises after E+5.
- Throughput: one key per BEATS+3 cycles with out_ready_i held at 1.
  - DONE lasts at least 1 cycle.
  - IDLE lasts at least 1 cycle; there is no result-to-accept bypass.
- Reset mid-operation (ACCUM, FOLD or DONE): the unit aborts to IDLE on the next edge, clears hash_val_o, and drops out_valid_o. The partial result is never presented.
- Simultaneous out_valid_o && out_ready_i: the transfer completes on that edge. in_ready_o = 1 on the next cycle. hash_val_o keeps its value until the next FOLD.
- in_ready_o and out_valid_o are decoded from registered state only, with no combinational input-to-output path.

## Test plan
- Default params, mode 0, bytes 0..7 = 01..08 → hash_val_o = 0x24. out_valid_o rises 5 edges after acceptance.
- Default params, mode 0, key all 0xFF → sum 0x7F8; hash_val_o = 0x07 + 0xF8 = 0xFF. Repeat with mode 3 → 0xFF.
- Default params, mode 1, bytes 01..08 → 0x08.
- Default params, mode 2, byte0 = 0x01 and other bytes 0x00 → 0x07. Same with key all 0x00 → 0x00.
- KEY_BYTES = 5, LANES = 2 (BEATS = 3), mode 0, bytes 10,20,30,40,50 (hex) → 0xF0.
  - out_valid_o rises after E+4.
  - Result confirms the partial final beat adds no pad.
- Handshake and reset:
  - Hold out_ready_i = 0 for 10 cycles in DONE: out_valid_o and hash_val_o stay stable, and a pending in_valid_i is not accepted.
  - Then pulse out_ready_i: in_ready_o rises on the next cycle.
  - Assert rst during ACCUM: out_valid_o never rises and hash_val_o reads 0.
